// File: rtl/exc_pkg.sv
// Shared types and constants for the exception controller and its priority encoder.
package exc_pkg;

  localparam int NUM_IRQ  = 4;
  localparam int IRQ_ID_W = 2;

  localparam logic [3:0] ESR_NONE   = 4'b0000;
  localparam logic [3:0] ESR_EXTIRQ = 4'b0001;
  localparam logic [3:0] ESR_BADOP  = 4'b0010;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    HANDLER = 2'd2
  } exc_state_e;

  function automatic logic [NUM_IRQ-1:0] irq_onehot(input logic [IRQ_ID_W-1:0] id);
    return NUM_IRQ'(1) << id;
  endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: bit 0 wins, valid flags any pending request.
module irq_prio_enc
  import exc_pkg::*;
(
  input  logic [NUM_IRQ-1:0]  req,
  output logic                vld,
  output logic [IRQ_ID_W-1:0] idx
);

  always_comb begin
    vld = |req;
    idx = '0;
    // Scan from the lowest priority down so the lowest set bit is written last.
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (req[i]) idx = IRQ_ID_W'(i);
    end
  end

endmodule

// File: rtl/exception_controller.sv
// Exception/interrupt entry controller: raises ExtIRQ, captures ELR/ESR on entry,
// acknowledges the serviced source and returns to IDLE on ERET.
module exception_controller
  import exc_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_IRQ-1:0]  IrqReq,
  input  logic                ExcTaken,
  input  logic                ERet,
  input  logic [3:0]          EStatusIn,
  input  logic [DATA_W-1:0]   PCIn,
  output logic                ExtIRQ,
  output logic [NUM_IRQ-1:0]  IrqAck,
  output logic [DATA_W-1:0]   ELR,
  output logic [3:0]          ESR,
  output logic [IRQ_ID_W-1:0] IrqId,
  output logic                InHandler,
  output logic                NestErr
);

  exc_state_e          state, state_next;
  logic                irq_vld;
  logic [IRQ_ID_W-1:0] irq_idx;
  logic                capture, ack_fire, latch_id, nest_hit;

  irq_prio_enc u_prio (
    .req (IrqReq),
    .vld (irq_vld),
    .idx (irq_idx)
  );

  always_comb begin
    state_next = state;
    capture    = 1'b0;
    ack_fire   = 1'b0;
    latch_id   = 1'b0;
    nest_hit   = 1'b0;
    case (state)
      IDLE: begin
        // A committed exception takes precedence over a new interrupt request.
        if (ExcTaken) begin
          capture    = 1'b1;
          state_next = HANDLER;
        end else if (irq_vld) begin
          latch_id   = 1'b1;
          state_next = REQ;
        end
      end
      REQ: begin
        if (ExcTaken) begin
          capture    = 1'b1;
          ack_fire   = 1'b1;
          state_next = HANDLER;
        end
      end
      HANDLER: begin
        nest_hit = ExcTaken;
        if (ERet) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      ExtIRQ    <= 1'b0;
      InHandler <= 1'b0;
      IrqAck    <= '0;
      ELR       <= '0;
      ESR       <= ESR_NONE;
      IrqId     <= '0;
      NestErr   <= 1'b0;
    end else begin
      state     <= state_next;
      ExtIRQ    <= (state_next == REQ);
      InHandler <= (state_next == HANDLER);
      IrqAck    <= ack_fire ? irq_onehot(IrqId) : '0;
      if (capture) begin
        ELR <= PCIn;
        ESR <= EStatusIn;
      end
      if (latch_id) IrqId <= irq_idx;
      if (nest_hit) NestErr <= 1'b1;
    end
  end

endmodule

// File: tb/tb_exception_controller.sv
// Directed and randomized checks of exception_controller against a flag-based reference model.
module tb_exception_controller;
  import exc_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  IrqReq;
  logic        ExcTaken, ERet;
  logic [3:0]  EStatusIn;
  logic [63:0] PCIn;
  logic        ExtIRQ;
  logic [3:0]  IrqAck;
  logic [63:0] ELR;
  logic [3:0]  ESR;
  logic [1:0]  IrqId;
  logic        InHandler, NestErr;

  int checks = 0;
  int errors = 0;

  // Reference model: two flags describe where the controller is.
  bit          m_pending, m_handling, m_nest;
  logic [63:0] m_elr;
  logic [3:0]  m_esr, m_ack;
  logic [1:0]  m_id;

  exception_controller #(.DATA_W(64)) dut (
    .clk       (clk),
    .reset     (reset),
    .IrqReq    (IrqReq),
    .ExcTaken  (ExcTaken),
    .ERet      (ERet),
    .EStatusIn (EStatusIn),
    .PCIn      (PCIn),
    .ExtIRQ    (ExtIRQ),
    .IrqAck    (IrqAck),
    .ELR       (ELR),
    .ESR       (ESR),
    .IrqId     (IrqId),
    .InHandler (InHandler),
    .NestErr   (NestErr)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pending = 0; m_handling = 0; m_nest = 0;
    m_elr = '0; m_esr = '0; m_ack = '0; m_id = '0;
  endtask

  task automatic check_model(input string where);
    chk({where, ".ExtIRQ"},    ExtIRQ,    m_pending);
    chk({where, ".InHandler"}, InHandler, m_handling);
    chk({where, ".IrqAck"},    IrqAck,    m_ack);
    chk({where, ".ELR"},       ELR,       m_elr);
    chk({where, ".ESR"},       ESR,       m_esr);
    chk({where, ".IrqId"},     IrqId,     m_id);
    chk({where, ".NestErr"},   NestErr,   m_nest);
  endtask

  // One clock: advance the model by the spec rules with the inputs held across the edge.
  task automatic tick(input string where);
    logic [3:0]  irq;
    logic        exc, ert;
    logic [63:0] pc;
    logic [3:0]  es;
    bit          found;
    irq = IrqReq; exc = ExcTaken; ert = ERet; pc = PCIn; es = EStatusIn;
    @(posedge clk);
    m_ack = '0;
    if (m_handling) begin
      if (exc) m_nest = 1;
      if (ert) m_handling = 0;
    end else if (m_pending) begin
      if (exc) begin
        m_elr = pc; m_esr = es;
        m_ack = 4'b0001 << m_id;
        m_pending = 0; m_handling = 1;
      end
    end else begin
      if (exc) begin
        m_elr = pc; m_esr = es; m_handling = 1;
      end else if (irq != 0) begin
        found = 0;
        for (int i = 0; i < 4; i++) begin
          if (irq[i] && !found) begin
            m_id = 2'(i);
            found = 1;
          end
        end
        m_pending = 1;
      end
    end
    #1;
    check_model(where);
  endtask

  task automatic pulse_reset(input string where);
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_model({where, ".async"});
    #1 reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; IrqReq = '0; ExcTaken = 0; ERet = 0; EStatusIn = '0; PCIn = '0;
    model_reset();
    #12;
    chk("rst.ExtIRQ", ExtIRQ, 0);
    chk("rst.IrqAck", IrqAck, 0);
    chk("rst.ELR", ELR, 0);
    chk("rst.ESR", ESR, 0);
    chk("rst.IrqId", IrqId, 0);
    chk("rst.InHandler", InHandler, 0);
    chk("rst.NestErr", NestErr, 0);
    reset = 1'b0;

    // Interrupt from source 2, then exception entry.
    IrqReq = 4'b0100;
    tick("irq2.req");
    chk("irq2.ExtIRQ", ExtIRQ, 1);
    chk("irq2.IrqId", IrqId, 2);
    IrqReq = '0; ExcTaken = 1; PCIn = 64'h40; EStatusIn = ESR_EXTIRQ;
    tick("irq2.entry");
    chk("irq2.ELR", ELR, 64'h40);
    chk("irq2.ESR", ESR, 4'b0001);
    chk("irq2.IrqAck", IrqAck, 4'b0100);
    chk("irq2.InHandler", InHandler, 1);
    ExcTaken = 0;
    tick("irq2.ackdone");
    chk("irq2.IrqAck_one", IrqAck, 0);
    ERet = 1;
    tick("irq2.eret");
    ERet = 0;

    // Priority and withdrawal during REQ.
    IrqReq = 4'b1010;
    tick("prio.req");
    chk("prio.IrqId", IrqId, 1);
    IrqReq = '0;
    tick("prio.hold1");
    tick("prio.hold2");
    chk("prio.ExtIRQ_held", ExtIRQ, 1);
    ExcTaken = 1; PCIn = 64'h1234; EStatusIn = ESR_EXTIRQ;
    tick("prio.entry");
    chk("prio.IrqAck", IrqAck, 4'b0010);
    ExcTaken = 0; ERet = 1;
    tick("prio.eret");
    ERet = 0;

    // Synchronous exception from IDLE.
    ExcTaken = 1; PCIn = 64'h1C; EStatusIn = ESR_BADOP;
    tick("sync.entry");
    chk("sync.ESR", ESR, 4'b0010);
    chk("sync.ELR", ELR, 64'h1C);
    chk("sync.IrqAck", IrqAck, 0);
    chk("sync.InHandler", InHandler, 1);
    ExcTaken = 0; ERet = 1;
    tick("sync.eret");
    chk("sync.idle", InHandler, 0);
    ERet = 0;

    // ExcTaken beats IrqReq in IDLE; nested entry in HANDLER.
    ExcTaken = 1; IrqReq = 4'b0001; PCIn = 64'h1C;
    tick("nest.entry");
    chk("nest.noExtIRQ", ExtIRQ, 0);
    PCIn = 64'h99;
    tick("nest.second");
    chk("nest.ELR", ELR, 64'h1C);
    chk("nest.NestErr", NestErr, 1);
    ERet = 1;
    tick("nest.eret_exc");
    chk("nest.idle", InHandler, 0);
    chk("nest.sticky", NestErr, 1);
    ExcTaken = 0; ERet = 0;
    tick("nest.reeval");
    chk("nest.ExtIRQ_after_idle", ExtIRQ, 1);

    // Reset while in REQ with IrqReq still asserted.
    pulse_reset("rstreq");
    chk("rstreq.NestErr", NestErr, 0);
    tick("rstreq.release");
    chk("rstreq.ExtIRQ", ExtIRQ, 1);
    tick("rstreq.hold");
    IrqReq = '0;

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      IrqReq    = 4'($urandom_range(0, 15));
      ExcTaken  = ($urandom_range(0, 3) == 0);
      ERet      = ($urandom_range(0, 3) == 0);
      EStatusIn = 4'($urandom_range(0, 15));
      PCIn      = {$urandom, $urandom};
      if ($urandom_range(0, 49) == 0) pulse_reset("rand.rst");
      tick("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/exception_controller.md
EXCEPTION_CONTROLLER -- requirements
Module: exception_controller

Interface
REQ-001 clk  in  1  single clock; all state updates on rising edge.
REQ-002 reset  in  1  asynchronous, active-high reset.
REQ-003 IrqReq  in  4  level interrupt requests from devices; bit 0 highest priority.
REQ-004 ExcTaken  in  1  one-cycle pulse: pipeline committed exception entry (decoder Exc propagated).
REQ-005 ERet  in  1  one-cycle pulse: ERET committed.
REQ-006 EStatusIn  in  4  decoder EStatus accompanying ExcTaken.
REQ-007 PCIn  in  64  PC of instruction accompanying ExcTaken.
REQ-008 ExtIRQ  out  1  interrupt request to main decoder.
REQ-009 IrqAck  out  4  one-hot, one-cycle acknowledge to serviced source.
REQ-010 ELR  out  64  saved exception link register.
REQ-011 ESR  out  4  saved exception status.
REQ-012 IrqId  out  2  index of the latched/serviced source.
REQ-013 InHandler  out  1  high while in HANDLER state.
REQ-014 NestErr  out  1  sticky flag: exception entry attempted while in HANDLER.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, REQ, HANDLER.
REQ-016 In IDLE with IrqReq != 0, the block SHALL latch the priority-encoded lowest set bit into IrqId and enter REQ on the next edge.
REQ-017 ExtIRQ SHALL be a registered output, high exactly while in REQ, and SHALL stay high until ExcTaken even if IrqReq is withdrawn.
REQ-018 In REQ on ExcTaken: ELR <= PCIn, ESR <= EStatusIn, IrqAck[IrqId] pulses for one cycle (the cycle after ExcTaken), and the state goes to HANDLER.
REQ-019 In IDLE on ExcTaken (synchronous exception, e.g. EStatusIn = 0010): ELR/ESR SHALL be captured, the state SHALL go to HANDLER, and no IrqAck SHALL be issued.
REQ-020 If IDLE sees both ExcTaken and IrqReq != 0 in the same cycle, ExcTaken SHALL win; IrqReq SHALL be ignored that cycle.
REQ-021 In HANDLER, ExtIRQ SHALL be 0 (no nesting); ExcTaken SHALL leave ELR/ESR unchanged and SHALL set NestErr.
REQ-022 In HANDLER on ERet, the state SHALL return to IDLE on the next edge; if ERet and ExcTaken coincide, ERet SHALL win and NestErr SHALL still be set.
REQ-023 ERet in IDLE or REQ SHALL be ignored.
REQ-024 Pending IrqReq SHALL be re-evaluated only in IDLE, which enforces at least one IDLE cycle between ERET and the next ExtIRQ.
REQ-025 ELR, ESR and IrqId SHALL hold their values until the next capture.
REQ-026 InHandler SHALL be registered and SHALL equal (state == HANDLER).

Reset
REQ-027 Reset SHALL asynchronously force: state IDLE, ExtIRQ 0, IrqAck 0, ELR 0, ESR 0000, IrqId 0, InHandler 0, NestErr 0.
REQ-028 Reset asserted mid-REQ or mid-HANDLER SHALL abandon the operation; no IrqAck SHALL be issued afterwards for that request.
REQ-029 NestErr SHALL be cleared only by reset.

Structure
REQ-030 A shared package exc_pkg SHALL hold: the state enum, NUM_IRQ = 4, and the EStatus constants ESR_NONE = 0000, ESR_EXTIRQ = 0001, ESR_BADOP = 0010.
REQ-031 A sub-module irq_prio_enc (4-bit fixed-priority encoder: valid + 2-bit index) SHALL be instantiated.

Verification
REQ-032 IrqReq = 0100 in IDLE -> ExtIRQ = 1 next cycle, IrqId = 2; ExcTaken with PCIn = 0x40, EStatusIn = 0001 -> ELR = 0x40, ESR = 0001, IrqAck = 0100 for one cycle, InHandler = 1.
REQ-033 IrqReq = 1010 -> IrqId = 1; withdraw IrqReq during REQ -> ExtIRQ stays 1 until ExcTaken.
REQ-034 ExcTaken with EStatusIn = 0010, PCIn = 0x1C in IDLE -> ESR = 0010, ELR = 0x1C, IrqAck = 0000, HANDLER; ERet -> IDLE next cycle.
REQ-035 In HANDLER: ExcTaken with PCIn = 0x99 -> ELR unchanged, NestErr = 1; ERet+ExcTaken in the same cycle -> IDLE.
REQ-036 Reset pulse while in REQ -> all outputs 0 asynchronously; no IrqAck after release; IrqReq still high -> ExtIRQ reasserted one cycle after reset release.
